sd_sync_data_in: RTL and testbench

SD_SYNC_DATA_IN -- requirements
Module: sd_sync_data_in

---
 rtl/sd_sync_data_in.sv | 80 ++++++++
 tb/tb_sd_sync_data_in.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sd_sync_data_in.sv
// Avalon-MM edge-capture input port: synchronizes asynchronous inputs, detects
// edges into sticky capture bits and raises a masked level interrupt.
module sd_sync_data_in #(
  parameter int WIDTH     = 16,
  parameter int EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] s1, s2, prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [1:0]       settle_cnt;

  logic             wr_en;
  logic             settled;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clear_bits;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign settled      = (settle_cnt == 2'd3);
  assign clear_bits   = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  assign unused_wdata = ^writedata;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det = s2 & ~prev;
      1:       edge_det = ~s2 & prev;
      default: edge_det = s2 ^ prev;
    endcase
  end

  // NOTE: state uses non-blocking assignments so s1 -> s2 -> prev shift by one
  // stage per clock instead of collapsing into a single register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1           <= '0;
      s2           <= '0;
      prev         <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      settle_cnt   <= 2'd0;
    end else begin
      s1   <= in_port;
      s2   <= s1;
      prev <= s2;
      if (!settled)
        settle_cnt <= settle_cnt + 2'd1;
      if (wr_en && address == 2'd2)
        irq_mask <= writedata[WIDTH-1:0];
      // A fresh edge wins over a same-cycle write-1-to-clear.
      edge_capture <= (edge_capture & ~clear_bits) | (settled ? edge_det : '0);
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = s2;
      2'd2:    readdata[WIDTH-1:0] = irq_mask;
      2'd3:    readdata[WIDTH-1:0] = edge_capture;
      default: readdata = '0;
    endcase
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_sd_sync_data_in.sv
// Scoreboard bench for sd_sync_data_in: a rising-edge build and an either-edge
// build share one bus; expectations are queued and checked at the falling edge.
module tb_sd_sync_data_in;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [15:0] in_port;
  logic [31:0] rd_r, rd_e;
  logic        irq_r, irq_e;

  sd_sync_data_in #(.WIDTH(16), .EDGE_TYPE(0)) dut_r (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_r), .irq(irq_r)
  );

  sd_sync_data_in #(.WIDTH(16), .EDGE_TYPE(2)) dut_e (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_e), .irq(irq_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // src: 0 rising readdata, 1 rising irq, 2 either readdata, 3 either irq
  typedef struct {
    string       name;
    int          src;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.src)
        0:       act = rd_r;
        1:       act = {31'b0, irq_r};
        2:       act = rd_e;
        default: act = {31'b0, irq_e};
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: actual %h required %h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input string name, input int src, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.src  = src;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic expect_rd(input string name, input logic [1:0] a,
                           input logic [31:0] e_r, input logic [31:0] e_e);
    address = a;
    push({name, "_rise"}, 0, e_r);
    push({name, "_either"}, 2, e_e);
  endtask

  task automatic expect_irq(input string name, input logic e_r, input logic e_e);
    push({name, "_rise"}, 1, {31'b0, e_r});
    push({name, "_either"}, 3, {31'b0, e_e});
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;

    // Registers read zero while reset is held, even with inputs high.
    expect_rd("rst_data", 2'd0, 32'h0, 32'h0);
    expect_irq("rst_irq", 1'b0, 1'b0);
    tick();
    expect_rd("rst_mask", 2'd2, 32'h0, 32'h0);
    tick();
    expect_rd("rst_cap", 2'd3, 32'h0, 32'h0);
    tick();

    // Levels present at reset release must not be captured.
    reset = 1'b0;
    ticks(10);
    expect_rd("settle_cap", 2'd3, 32'h0, 32'h0);
    expect_irq("settle_irq", 1'b0, 1'b0);
    tick();
    expect_rd("settle_data", 2'd0, 32'h0000FFFF, 32'h0000FFFF);
    tick();
    expect_rd("reserved_rd", 2'd1, 32'h0, 32'h0);
    tick();

    // Rising edge on bit 0 with mask 1: exact two-clock capture latency.
    bus_write(2'd2, 32'h00000001);
    in_port = 16'hFFFE;
    ticks(4);
    bus_write(2'd3, 32'h0000FFFF);
    in_port = 16'hFFFF;
    tick();                                  // sampled into s1
    expect_rd("lat_k_cap", 2'd3, 32'h0, 32'h0);
    expect_irq("lat_k_irq", 1'b0, 1'b0);
    tick();                                  // visible in data
    expect_rd("lat_k1_data", 2'd0, 32'h0000FFFF, 32'h0000FFFF);
    expect_irq("lat_k1_irq", 1'b0, 1'b0);
    tick();                                  // captured
    expect_rd("lat_k2_cap", 2'd3, 32'h00000001, 32'h00000001);
    expect_irq("lat_k2_irq", 1'b1, 1'b1);
    tick();

    // Build capture=0003 on both, then clear bit 0 only.
    in_port = 16'hFFFE;
    ticks(4);
    in_port = 16'hFFFC;
    ticks(4);
    in_port = 16'hFFFE;
    ticks(4);
    expect_rd("cap3", 2'd3, 32'h00000003, 32'h00000003);
    expect_irq("cap3_irq", 1'b1, 1'b1);
    tick();
    bus_write(2'd3, 32'h00000001);
    expect_rd("w1c_cap", 2'd3, 32'h00000002, 32'h00000002);
    expect_irq("w1c_irq", 1'b0, 1'b0);
    tick();

    // Rising edge on bit 4 in the same clock as its clear: set wins.
    in_port = 16'hFFEE;
    ticks(4);
    expect_rd("b4_fall", 2'd3, 32'h00000002, 32'h00000012);
    tick();
    in_port = 16'hFFFE;
    tick();
    tick();
    bus_write(2'd3, 32'h00000010);
    expect_rd("set_wins", 2'd3, 32'h00000012, 32'h00000012);
    tick();

    // Falling edge on bit 15: only the either-edge build captures it.
    in_port = 16'h7FFE;
    ticks(4);
    expect_rd("b15_fall", 2'd3, 32'h00000012, 32'h00008012);
    tick();

    // Capture 00F0 with full mask, then a one-clock reset mid-run.
    bus_write(2'd3, 32'h0000FFFF);
    in_port = 16'h7F0E;
    ticks(4);
    in_port = 16'h7FFE;
    ticks(4);
    expect_rd("capF0", 2'd3, 32'h000000F0, 32'h000000F0);
    tick();
    bus_write(2'd2, 32'h0000FFFF);
    expect_rd("maskFFFF", 2'd2, 32'h0000FFFF, 32'h0000FFFF);
    expect_irq("maskFFFF_irq", 1'b1, 1'b1);
    tick();
    reset = 1'b1;
    expect_rd("async_rst_cap", 2'd3, 32'h0, 32'h0);
    expect_irq("async_rst_irq", 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    expect_rd("post_rst_mask", 2'd2, 32'h0, 32'h0);
    expect_irq("post_rst_irq", 1'b0, 1'b0);
    tick();
    ticks(10);
    expect_rd("resettle_cap", 2'd3, 32'h0, 32'h0);
    tick();
    expect_rd("resettle_data", 2'd0, 32'h00007FFE, 32'h00007FFE);
    tick();

    // Writes to data and reserved addresses leave readback unchanged.
    bus_write(2'd0, 32'hFFFFFFFF);
    bus_write(2'd1, 32'hFFFFFFFF);
    expect_rd("ro_data", 2'd0, 32'h00007FFE, 32'h00007FFE);
    tick();
    expect_rd("ro_reserved", 2'd1, 32'h0, 32'h0);
    tick();
    expect_rd("ro_mask", 2'd2, 32'h0, 32'h0);
    tick();
    expect_rd("ro_cap", 2'd3, 32'h0, 32'h0);
    expect_irq("ro_irq", 1'b0, 1'b0);
    tick();
    tick();

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual %0d pending required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
